// File: rtl/opb_regbank_pkg.sv
// Shared types and helpers for the OPB register bank: FSM encoding,
// register width, address-to-index and byte-enable-to-mask conversion.
package opb_regbank_pkg;

    localparam int REG_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACK  = 2'b01,
        ST_WAIT = 2'b10
    } opb_state_t;

    // Word index inside the bank; the two byte-offset address bits drop out in the shift.
    function automatic logic [31:0] addr_to_index(input logic [31:0] addr,
                                                  input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

    // be[3] is OPB_BE[0], which covers the most significant user byte.
    function automatic logic [REG_WIDTH-1:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/opb_reg_slice.sv
// One 32-bit byte-enabled control register with synchronous reset and a
// one-cycle strobe that follows every committed write.
module opb_reg_slice
    import opb_regbank_pkg::*;
#(
    parameter logic [REG_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [REG_WIDTH-1:0] wr_data,
    input  logic [REG_WIDTH-1:0] wr_mask,
    output logic [REG_WIDTH-1:0] q,
    output logic                 wr_stb
);

    // The strobe fires even when the mask is empty and the value is unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            q      <= RESET_VAL;
            wr_stb <= 1'b0;
        end else begin
            wr_stb <= wr_en;
            if (wr_en) begin
                q <= (q & ~wr_mask) | (wr_data & wr_mask);
            end
        end
    end

endmodule

// File: rtl/opb_register_bank.sv
// OPB slave exposing C_NUM_REGS 32-bit registers, each either a read/write
// control register or a read-only status word supplied by user logic.
module opb_register_bank
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_4000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_40FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 4,
    parameter logic [15:0] C_RO_MASK    = 16'h0000,
    parameter logic [31:0] C_RESET_VAL  = 32'h0
) (
    input  logic                          OPB_Clk,
    input  logic                          OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]       OPB_ABus,
    input  logic [0:3]                    OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]       OPB_DBus,
    input  logic                          OPB_RNW,
    input  logic                          OPB_select,
    input  logic                          OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]       Sl_DBus,
    output logic                          Sl_xferAck,
    output logic                          Sl_errAck,
    output logic                          Sl_retry,
    output logic                          Sl_toutSup,
    output logic [C_NUM_REGS*32-1:0]      user_data_out,
    input  logic [C_NUM_REGS*32-1:0]      user_data_in,
    output logic [C_NUM_REGS-1:0]         user_wr_stb
);

    opb_state_t           state_q;
    opb_state_t           state_next;
    logic [31:0]          addr;
    logic [31:0]          idx;
    logic                 idx_valid;
    logic                 hit;
    logic                 take;
    logic [REG_WIDTH-1:0] wr_data;
    logic [REG_WIDTH-1:0] wr_mask;
    logic [C_NUM_REGS-1:0] wr_en;
    logic [REG_WIDTH-1:0] reg_q [C_NUM_REGS];
    logic [REG_WIDTH-1:0] rd_sel;
    logic [REG_WIDTH-1:0] rd_q;
    logic                 unused_inputs;

    assign unused_inputs = OPB_seqAddr;

    assign addr      = OPB_ABus;
    assign idx       = addr_to_index(addr, C_BASEADDR);
    assign idx_valid = idx < 32'(C_NUM_REGS);
    assign hit       = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign take      = (state_q == ST_IDLE) && hit;
    assign wr_data   = OPB_DBus;
    assign wr_mask   = be_to_mask(OPB_BE);

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // WAIT absorbs a master that keeps select high, so one select gets one ack.
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE: if (hit) state_next = ST_ACK;
            ST_ACK:  state_next = ST_WAIT;
            ST_WAIT: if (!OPB_select) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_en  = '0;
        rd_sel = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (idx_valid && (idx == 32'(i))) begin
                if (take && !OPB_RNW && !C_RO_MASK[i]) begin
                    wr_en[i] = 1'b1;
                end
                rd_sel = C_RO_MASK[i] ? user_data_in[i*32 +: 32] : reg_q[i];
            end
        end
    end

    // Read data is captured on the edge entering ACK, so RO status is a snapshot.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= (take && OPB_RNW) ? rd_sel : '0;
        end
    end

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_reg
        if (C_RO_MASK[g]) begin : g_ro
            assign reg_q[g]       = '0;
            assign user_wr_stb[g] = 1'b0;
        end else begin : g_rw
            opb_reg_slice #(
                .RESET_VAL (C_RESET_VAL)
            ) u_slice (
                .clock   (OPB_Clk),
                .reset   (OPB_Rst),
                .wr_en   (wr_en[g]),
                .wr_data (wr_data),
                .wr_mask (wr_mask),
                .q       (reg_q[g]),
                .wr_stb  (user_wr_stb[g])
            );
        end
        assign user_data_out[g*32 +: 32] = reg_q[g];
    end

    assign Sl_xferAck = (state_q == ST_ACK);
    assign Sl_DBus    = (state_q == ST_ACK) ? rd_q : '0;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank.sv
// Directed bench for opb_register_bank with four registers, register 3
// read-only; expected values are hand-computed from the bus behaviour.
module tb_opb_register_bank;

    logic          clk;
    logic          rst;
    logic [0:31]   opb_abus;
    logic [0:3]    opb_be;
    logic [0:31]   opb_dbus;
    logic          opb_rnw;
    logic          opb_select;
    logic          opb_seq_addr;
    logic [0:31]   sl_dbus;
    logic          sl_xfer_ack;
    logic          sl_err_ack;
    logic          sl_retry;
    logic          sl_tout_sup;
    logic [127:0]  user_data_out;
    logic [127:0]  user_data_in;
    logic [3:0]    user_wr_stb;

    int            total_count = 0;
    int            bad_count   = 0;

    int            ack_count;
    int            latency;
    logic          junk;
    logic [31:0]   cap_dbus;
    logic [3:0]    cap_stb;
    logic [127:0]  cap_out;

    opb_register_bank #(
        .C_BASEADDR   (32'h0100_4000),
        .C_HIGHADDR   (32'h0100_40FF),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_NUM_REGS   (4),
        .C_RO_MASK    (16'h0008),
        .C_RESET_VAL  (32'h0)
    ) dut (
        .OPB_Clk       (clk),
        .OPB_Rst       (rst),
        .OPB_ABus      (opb_abus),
        .OPB_BE        (opb_be),
        .OPB_DBus      (opb_dbus),
        .OPB_RNW       (opb_rnw),
        .OPB_select    (opb_select),
        .OPB_seqAddr   (opb_seq_addr),
        .Sl_DBus       (sl_dbus),
        .Sl_xferAck    (sl_xfer_ack),
        .Sl_errAck     (sl_err_ack),
        .Sl_retry      (sl_retry),
        .Sl_toutSup    (sl_tout_sup),
        .user_data_out (user_data_out),
        .user_data_in  (user_data_in),
        .user_wr_stb   (user_wr_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        total_count++;
        assert (observed === expected) else begin
            bad_count++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rnw, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] data);
        opb_rnw    = rnw;
        opb_abus   = addr;
        opb_be     = be;
        opb_dbus   = data;
        opb_select = 1'b1;
    endtask

    // Holds select for 'hold' edges, then idles three more, recording what the slave did.
    task automatic runTransfer(input logic rnw, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] data,
                               input int hold);
        ack_count = 0;
        latency   = -1;
        junk      = 1'b0;
        cap_dbus  = '0;
        cap_stb   = '0;
        cap_out   = '0;
        applyStimulus(rnw, addr, be, data);
        for (int c = 0; c <= hold + 3; c++) begin
            if (sl_xfer_ack) begin
                ack_count++;
                if (latency < 0) begin
                    latency  = c;
                    cap_dbus = sl_dbus;
                    cap_stb  = user_wr_stb;
                    cap_out  = user_data_out;
                end
            end else if ((sl_dbus != 32'h0) || (user_wr_stb != 4'h0)) begin
                junk = 1'b1;
            end
            if (c == hold) opb_select = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst          = 1'b1;
        opb_abus     = '0;
        opb_be       = '0;
        opb_dbus     = '0;
        opb_rnw      = 1'b0;
        opb_select   = 1'b0;
        opb_seq_addr = 1'b0;
        user_data_in = {32'hCAFE_F00D, 32'h5555_5555, 32'hAAAA_AAAA, 32'h5A5A_5A5A};
        repeat (2) @(negedge clk);

        checkOutput("rst_ack",  128'(sl_xfer_ack), 128'h0);
        checkOutput("rst_dbus", 128'(sl_dbus), 128'h0);
        checkOutput("rst_stb",  128'(user_wr_stb), 128'h0);
        checkOutput("rst_out",  user_data_out, 128'h0);
        checkOutput("tied_outs", 128'({sl_err_ack, sl_retry, sl_tout_sup}), 128'h0);
        rst = 1'b0;
        @(negedge clk);

        runTransfer(1'b0, 32'h0100_4004, 4'b1111, 32'hDEAD_BEEF, 1);
        checkOutput("w1_acks", 128'(ack_count), 128'd1);
        checkOutput("w1_lat",  128'(latency), 128'd1);
        checkOutput("w1_reg1", 128'(cap_out[63:32]), 128'hDEAD_BEEF);
        checkOutput("w1_stb",  128'(cap_stb), 128'b0010);
        checkOutput("w1_junk", 128'(junk), 128'h0);

        runTransfer(1'b0, 32'h0100_4004, 4'b0101, 32'h1122_3344, 1);
        checkOutput("w2_reg1", 128'(cap_out[63:32]), 128'hDE22_BE44);
        checkOutput("w2_stb",  128'(cap_stb), 128'b0010);

        runTransfer(1'b1, 32'h0100_4004, 4'b0000, 32'h0, 1);
        checkOutput("r1_acks", 128'(ack_count), 128'd1);
        checkOutput("r1_dbus", 128'(cap_dbus), 128'hDE22_BE44);
        checkOutput("r1_junk", 128'(junk), 128'h0);
        checkOutput("r1_stb",  128'(cap_stb), 128'h0);

        runTransfer(1'b1, 32'h0100_400C, 4'b1111, 32'h0, 1);
        checkOutput("ro_read", 128'(cap_dbus), 128'hCAFE_F00D);

        runTransfer(1'b0, 32'h0100_400C, 4'b1111, 32'h1234_5678, 1);
        checkOutput("ro_w_acks", 128'(ack_count), 128'd1);
        checkOutput("ro_w_stb",  128'(cap_stb), 128'h0);
        checkOutput("ro_w_out",  128'(cap_out[127:96]), 128'h0);
        checkOutput("ro_w_junk", 128'(junk), 128'h0);

        runTransfer(1'b1, 32'h0100_400C, 4'b1111, 32'h0, 1);
        checkOutput("ro_reread", 128'(cap_dbus), 128'hCAFE_F00D);

        runTransfer(1'b1, 32'h0100_4010, 4'b1111, 32'h0, 1);
        checkOutput("idx4_r_acks", 128'(ack_count), 128'd1);
        checkOutput("idx4_r_dbus", 128'(cap_dbus), 128'h0);

        runTransfer(1'b0, 32'h0100_4010, 4'b1111, 32'hFFFF_FFFF, 1);
        checkOutput("idx4_w_acks", 128'(ack_count), 128'd1);
        checkOutput("idx4_w_stb",  128'(cap_stb), 128'h0);
        checkOutput("idx4_w_out",  cap_out, {96'h0, 32'hDE22_BE44, 32'h0} >> 0);

        runTransfer(1'b0, 32'h0100_4100, 4'b1111, 32'hFFFF_FFFF, 3);
        checkOutput("miss_w_acks", 128'(ack_count), 128'd0);
        checkOutput("miss_w_junk", 128'(junk), 128'h0);
        checkOutput("miss_w_out",  user_data_out, {64'h0, 32'hDE22_BE44, 32'h0});

        runTransfer(1'b1, 32'h0100_4100, 4'b1111, 32'h0, 3);
        checkOutput("miss_r_acks", 128'(ack_count), 128'd0);

        runTransfer(1'b0, 32'h0100_4000, 4'b1111, 32'h1234_5678, 1);
        checkOutput("w0_lat", 128'(latency), 128'd1);
        runTransfer(1'b0, 32'h0100_4000, 4'b1000, 32'hFF00_0000, 1);
        checkOutput("w0_msb_lane", 128'(cap_out[31:0]), 128'hFF34_5678);
        checkOutput("w0_stb", 128'(cap_stb), 128'b0001);

        runTransfer(1'b0, 32'h0100_4008, 4'b0000, 32'hFFFF_FFFF, 1);
        checkOutput("be0_stb", 128'(cap_stb), 128'b0100);
        checkOutput("be0_reg2", 128'(cap_out[95:64]), 128'h0);

        runTransfer(1'b1, 32'h0100_4004, 4'b1111, 32'h0, 5);
        checkOutput("hold5_acks", 128'(ack_count), 128'd1);
        checkOutput("hold5_lat",  128'(latency), 128'd1);
        checkOutput("hold5_junk", 128'(junk), 128'h0);
        runTransfer(1'b1, 32'h0100_4000, 4'b1111, 32'h0, 1);
        checkOutput("after_hold_acks", 128'(ack_count), 128'd1);
        checkOutput("after_hold_dbus", 128'(cap_dbus), 128'hFF34_5678);

        // Reset arriving while the write is already in its ACK cycle.
        applyStimulus(1'b0, 32'h0100_4000, 4'b1111, 32'h0BAD_F00D);
        @(negedge clk);
        checkOutput("pre_rst_ack",  128'(sl_xfer_ack), 128'd1);
        checkOutput("pre_rst_reg0", 128'(user_data_out[31:0]), 128'h0BAD_F00D);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_ack_ack",  128'(sl_xfer_ack), 128'h0);
        checkOutput("rst_ack_out",  user_data_out, 128'h0);
        checkOutput("rst_ack_stb",  128'(user_wr_stb), 128'h0);
        checkOutput("rst_ack_dbus", 128'(sl_dbus), 128'h0);
        rst        = 1'b0;
        opb_select = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ack", 128'(sl_xfer_ack), 128'h0);
        @(negedge clk);

        // Reset sampled on the same edge as a hitting write must win.
        runTransfer(1'b0, 32'h0100_4004, 4'b1111, 32'h0000_0077, 1);
        checkOutput("pre_race_reg1", 128'(cap_out[63:32]), 128'h77);
        applyStimulus(1'b0, 32'h0100_4004, 4'b1111, 32'hFFFF_FFFF);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("race_ack",  128'(sl_xfer_ack), 128'h0);
        checkOutput("race_reg1", 128'(user_data_out[63:32]), 128'h0);
        checkOutput("race_stb",  128'(user_wr_stb), 128'h0);
        rst        = 1'b0;
        opb_select = 1'b0;
        @(negedge clk);
        checkOutput("race_after_ack",  128'(sl_xfer_ack), 128'h0);
        checkOutput("race_after_reg1", 128'(user_data_out[63:32]), 128'h0);

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule

// File: doc/opb_register_bank.md
OPB_REGISTER_BANK -- requirements
Module: opb_register_bank

Interface
REQ-001 C_BASEADDR, 32'h01004000, first byte address of bank.
REQ-002 C_HIGHADDR, 32'h010040FF, last byte address of bank.
REQ-003 C_OPB_AWIDTH, 32, address bus width; C_OPB_DWIDTH, 32, data bus width (only 32 supported).
REQ-004 C_NUM_REGS, 4, number of 32-bit registers (1..16).
REQ-005 C_RO_MASK, 0, bit i=1: register i is read-only status (user-to-PPC); bit i=0: read/write control (PPC-to-user).
REQ-006 C_RESET_VAL, 32'h0, reset value of every read/write register.
REQ-007 OPB_Clk  in  1  single clock for the whole block.
REQ-008 OPB_Rst  in  1  reset; synchronous, active-high.
REQ-009 OPB_ABus  in  [0:31]  byte address; OPB_BE  in  [0:3]  byte enables; OPB_DBus  in  [0:31]  write data.
REQ-010 OPB_RNW  in  1  1=read; OPB_select  in  1  transfer request; OPB_seqAddr  in  1  ignored.
REQ-011 Sl_DBus  out  [0:31]  read data; Sl_xferAck  out  1  transfer done; Sl_errAck, Sl_retry, Sl_toutSup  out  1 each, tied 0.
REQ-012 user_data_out  out  [C_NUM_REGS*32-1:0]  register i on bits [32i+31:32i].
REQ-013 user_data_in  in  [C_NUM_REGS*32-1:0]  status word for RO register i, same packing.
REQ-014 user_wr_stb  out  [C_NUM_REGS-1:0]  one-cycle pulse per committed write to RW register i.

Function
REQ-015 Bit mapping: OPB_DBus[0] = user bit 31; OPB_BE[k] covers OPB_DBus[8k:8k+7] = user bits [31-8k:24-8k].
REQ-016 Hit = OPB_select & C_BASEADDR <= OPB_ABus <= C_HIGHADDR; index = (OPB_ABus - C_BASEADDR) >> 2, ABus[30:31] ignored.
REQ-017 FSM states IDLE, ACK, WAIT; IDLE->ACK on hit; ACK->WAIT unconditionally; WAIT->IDLE when OPB_select=0; WAIT holds while OPB_select=1.
REQ-018 Sl_xferAck high exactly in state ACK: one cycle, asserted the cycle after hit is sampled; never twice per select assertion.
REQ-019 Write (RNW=0), index<C_NUM_REGS, RW register: enabled bytes updated on the edge entering ACK; user_data_out shows new value while Sl_xferAck=1.
REQ-020 user_wr_stb[i] high in the ACK cycle of any write to RW register i, including BE=4'b0000 (value unchanged, strobe still fires).
REQ-021 Write to RO register or index>=C_NUM_REGS: no state change, no strobe, still acked.
REQ-022 Read: Sl_DBus = RW stored value, or RO user_data_in sampled on the edge entering ACK; index>=C_NUM_REGS reads 0; BE ignored on reads.
REQ-023 Sl_DBus SHALL be 0 whenever Sl_xferAck=0 (OR-bus compliance).
REQ-024 user_data_out bits of RO registers SHALL be 0.
REQ-025 Non-hit select (address outside range): no ack, no state change, FSM stays IDLE.

Reset
REQ-026 OPB_Rst=1 at a clock edge: FSM->IDLE, RW registers->C_RESET_VAL, Sl_xferAck=0, Sl_DBus=0, user_wr_stb=0.
REQ-027 Reset during ACK or WAIT: transfer abandoned, no ack issued, no write committed on that edge; master times out.
REQ-028 Reset has priority over any simultaneous write.

Structure
REQ-029 Shared package opb_regbank_pkg: FSM state encodings, register width constant (32), address-to-index function, BE-to-bitmask function.
REQ-030 One sub-module opb_reg_slice: single 32-bit byte-enabled register with synchronous reset and write strobe, instantiated per RW register.

Verification (C_NUM_REGS=4, C_RO_MASK=4'b1000, C_RESET_VAL=0)
REQ-031 Write 0xDEADBEEF, BE=1111, addr 0x01004004 -> xferAck 1 cycle after select; user_data_out[63:32]=0xDEADBEEF; user_wr_stb=4'b0010 that cycle only.
REQ-032 Then write 0x11223344, BE=0101, same addr -> reg1=0xDE22BE44; read back returns 0xDE22BE44 on Sl_DBus during ack only, 0 otherwise.
REQ-033 user_data_in[127:96]=0xCAFEF00D, read 0x0100400C -> Sl_DBus=0xCAFEF00D; write there -> no strobe, reads still 0xCAFEF00D.
REQ-034 Read 0x01004010 (in range, index 4) -> ack, data 0; access 0x01004100 -> no ack, FSM stays IDLE.
REQ-035 Master holds select 5 cycles -> exactly one xferAck; next select after deassert acked again.
REQ-036 Assert OPB_Rst in ACK of a write to reg0 -> no ack, reg0=0, user_wr_stb=0, FSM IDLE next cycle.
